// File: rtl/unsig_int_to_float_if.sv
// Handshake bundle for the unsigned-int to float converter.
// The master side supplies the operand and accepts the result;
// the slave side is the converter itself.
interface unsig_int_to_float_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    output output_z_ack,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    input  output_z_ack,
    output input_a_ack,
    output output_z,
    output output_z_stb
  );
endinterface

// File: rtl/unsig_int_to_float.sv
// Multi-cycle 32-bit unsigned integer to IEEE-754 single conversion,
// round to nearest / ties to even, stb/ack handshakes on both sides.
// Optional macro UITOF_FAST_NORM_EN: normalise in a single cycle with a
// leading-zero count and barrel shift instead of one bit per cycle.
module unsig_int_to_float #(
  parameter int EXP_BIAS = 127
) (
  input  logic                       clk,
  input  logic                       rst,
  unsig_int_to_float_if.slave        bus
);

  localparam logic [7:0] BIAS8 = 8'(EXP_BIAS);

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT   = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PACK      = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_value;
  logic [31:0] w_value_next;
  logic [7:0]  r_exp;
  logic [7:0]  w_exp_next;
  logic [23:0] r_man;
  logic [23:0] w_man_next;
  logic [31:0] r_z;
  logic [31:0] w_z_next;
  logic        r_ack;
  logic        w_ack_next;
  logic        r_stb;
  logic        w_stb_next;

  // Rounding fields, meaningful once the value is normalised (bit 31 set)
  logic        w_guard;
  logic        w_round_bit;
  logic        w_sticky;
  logic        w_round_up;
  logic [24:0] w_man_inc;

  assign w_guard     = r_value[7];
  assign w_round_bit = r_value[6];
  assign w_sticky    = |r_value[5:0];
  assign w_round_up  = w_guard & (w_round_bit | w_sticky | r_value[8]);
  assign w_man_inc   = {1'b0, r_value[31:8]} + 25'd1;

`ifdef UITOF_FAST_NORM_EN
  logic [5:0] w_lz;

  // Leading-zero count of the working value (only used on nonzero values)
  always_comb begin : lz_count
    logic found;
    found = 1'b0;
    w_lz  = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (r_value[i]) found = 1'b1;
        else            w_lz  = w_lz + 6'd1;
      end
    end
  end
`endif

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GET_A;
      r_value <= 32'h0;
      r_exp   <= 8'h0;
      r_man   <= 24'h0;
      r_z     <= 32'h0;
      r_ack   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_value <= w_value_next;
      r_exp   <= w_exp_next;
      r_man   <= w_man_next;
      r_z     <= w_z_next;
      r_ack   <= w_ack_next;
      r_stb   <= w_stb_next;
    end
  end

  // Next-state sequencing
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GET_A:     if (r_ack && bus.input_a_stb) w_state_next = CONVERT;
      CONVERT:   w_state_next = (r_value == 32'h0) ? PUT_Z : NORMALISE;
`ifdef UITOF_FAST_NORM_EN
      NORMALISE: w_state_next = ROUND;
`else
      NORMALISE: if (r_value[31]) w_state_next = ROUND;
`endif
      ROUND:     w_state_next = PACK;
      PACK:      w_state_next = PUT_Z;
      PUT_Z:     if (r_stb && bus.output_z_ack) w_state_next = GET_A;
      default:   w_state_next = GET_A;
    endcase
  end

  // Datapath and registered-output updates for each state
  always_comb begin
    w_value_next = r_value;
    w_exp_next   = r_exp;
    w_man_next   = r_man;
    w_z_next     = r_z;
    w_ack_next   = r_ack;
    w_stb_next   = r_stb;
    case (r_state)
      GET_A: begin
        w_ack_next = 1'b1;
        if (r_ack && bus.input_a_stb) begin
          w_value_next = bus.input_a;
          w_ack_next   = 1'b0;
        end
      end
      CONVERT: begin
        if (r_value == 32'h0) w_z_next   = 32'h0;
        else                  w_exp_next = 8'd31;
      end
      NORMALISE: begin
`ifdef UITOF_FAST_NORM_EN
        w_value_next = r_value << w_lz;
        w_exp_next   = 8'd31 - {2'b00, w_lz};
`else
        if (!r_value[31]) begin
          w_value_next = {r_value[30:0], 1'b0};
          w_exp_next   = r_exp - 8'd1;
        end
`endif
      end
      ROUND: begin
        w_man_next = r_value[31:8];
        if (w_round_up) begin
          if (w_man_inc[24]) begin
            // mantissa carried out to 2^24: renormalise by one place
            w_man_next = 24'h800000;
            w_exp_next = r_exp + 8'd1;
          end else begin
            w_man_next = w_man_inc[23:0];
          end
        end
      end
      PACK: begin
        w_z_next   = {1'b0, r_exp + BIAS8, r_man[22:0]};
        w_stb_next = 1'b1;
      end
      PUT_Z: begin
        // zero operands arrive here with stb low and raise it one cycle later
        w_stb_next = !(r_stb && bus.output_z_ack);
      end
      default: ;
    endcase
  end

  assign bus.input_a_ack  = r_ack;
  assign bus.output_z     = r_z;
  assign bus.output_z_stb = r_stb;

endmodule

// File: tb/tb_unsig_int_to_float.sv
// Directed bench for unsig_int_to_float: values, latency (per build),
// backpressure and mid-conversion reset.
module tb_unsig_int_to_float;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  unsig_int_to_float_if bus();

  unsig_int_to_float #(.EXP_BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int NVEC = 12;
  // operand, expected float, leading zeros (-1 marks the zero operand)
  logic [31:0] op_tab [NVEC] = '{32'h00000002, 32'h00000000, 32'h00000007, 32'hFFFFFFFF,
                                 32'h80000000, 32'h01000001, 32'h01000003, 32'h01000005,
                                 32'h02000005, 32'h02000007, 32'h00FFFFFF, 32'h00000001};
  logic [31:0] z_tab  [NVEC] = '{32'h40000000, 32'h00000000, 32'h40E00000, 32'h4F800000,
                                 32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4B800002,
                                 32'h4C000001, 32'h4C000002, 32'h4B7FFFFF, 32'h3F800000};
  int          lz_tab [NVEC] = '{30, -1, 29, 0, 0, 7, 7, 7, 6, 6, 8, 31};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input int lz);
    if (lz < 0) return 2;
`ifdef UITOF_FAST_NORM_EN
    return 4;
`else
    return lz + 4;
`endif
  endfunction

  // One full transaction; stall > 0 holds output_z_ack low that many cycles
  // while a competing operand is offered.
  task automatic do_convert(input string tag, input logic [31:0] op,
                            input logic [31:0] exp_z, input int lz, input int stall);
    int cnt;
    logic [31:0] z_seen;
    cnt = 0;
    while (bus.input_a_ack !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_val({tag, " ack_ready"}, 32'(bus.input_a_ack), 32'd1);
    bus.input_a     = op;
    bus.input_a_stb = 1'b1;
    @(negedge clk);
    bus.input_a_stb = 1'b0;
    bus.input_a     = 32'hDEADBEEF;
    check_val({tag, " ack_drop"}, 32'(bus.input_a_ack), 32'd0);
    cnt = 0;
    while (bus.output_z_stb !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_val({tag, " latency"}, 32'(cnt), 32'(exp_latency(lz)));
    check_val({tag, " z"}, bus.output_z, exp_z);
    z_seen = bus.output_z;
    for (int s = 0; s < stall; s++) begin
      bus.input_a     = 32'h12345678;
      bus.input_a_stb = 1'b1;
      @(negedge clk);
      check_val({tag, " hold_z"}, bus.output_z, z_seen);
      check_val({tag, " hold_stb"}, 32'(bus.output_z_stb), 32'd1);
      check_val({tag, " hold_ack"}, 32'(bus.input_a_ack), 32'd0);
    end
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b1;
    @(negedge clk);
    bus.output_z_ack = 1'b0;
    check_val({tag, " stb_fall"}, 32'(bus.output_z_stb), 32'd0);
    @(negedge clk);
    check_val({tag, " ack_back"}, 32'(bus.input_a_ack), 32'd1);
    $display("xfer %s op=%h z=%h latency=%0d", tag, op, z_seen, cnt);
  endtask

  initial begin
    int stb_seen;
    bus.input_a      = 32'h0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst ack", 32'(bus.input_a_ack), 32'd0);
    check_val("rst stb", 32'(bus.output_z_stb), 32'd0);
    check_val("rst z", bus.output_z, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_val("ack after reset", 32'(bus.input_a_ack), 32'd1);

    for (int v = 0; v < NVEC; v++)
      do_convert($sformatf("vec%0d", v), op_tab[v], z_tab[v], lz_tab[v], 0);

    // backpressure: result held for 5 cycles with a competing operand offered
    do_convert("bp", 32'h00000007, 32'h40E00000, 29, 5);

    // reset during conversion of operand 2, ten edges after the transfer
    bus.input_a     = 32'h00000002;
    bus.input_a_stb = 1'b1;
    @(negedge clk);
    bus.input_a_stb = 1'b0;
    stb_seen = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (bus.output_z_stb === 1'b1) stb_seen++;
    end
`ifndef UITOF_FAST_NORM_EN
    check_val("mid stb before rst", 32'(stb_seen), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid rst stb", 32'(bus.output_z_stb), 32'd0);
    check_val("mid rst z", bus.output_z, 32'h0);
    check_val("mid rst ack", 32'(bus.input_a_ack), 32'd0);
    @(negedge clk);
    check_val("mid ack after rst", 32'(bus.input_a_ack), 32'd1);
    stb_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.output_z_stb === 1'b1) stb_seen++;
    end
    check_val("mid no stb", 32'(stb_seen), 32'd0);
    $display("xfer mid_reset op=00000002 aborted");
    do_convert("after_rst", 32'h00000001, 32'h3F800000, 31, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
